fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the five-stage MIPS core.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched word into IF/ID, whose instruction field feeds the decode controller's opcode/funct inputs.
- Consumes the controller's jump-select code and the ID-stage branch decision to redirect the PC. Branches and jumps use a single architectural delay slot, so there is no flush.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IM_AW, 10, instruction-memory word-address width (1024 words).
- NOP_WORD, 32'h0000_0000, word delivered to IF/ID on out-of-range fetch and after reset.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  from hazard unit; freezes PC and IF/ID
- id_jsel  in  3  jump select from decode: 000 none, 001 jal, 010 jr, 011 j, 100 jialc, 101 ji
- id_br_taken  in  1  branch resolved taken in ID (beq/bne/bnzalr comparator output)
- id_imm16  in  16  ID instruction [15:0]
- id_imm26  in  26  ID instruction [25:0]
- id_rs_val  in  32  forwarded register value for jr/jialc/ji
- imem_addr  out  IM_AW  word address to instruction ROM
- imem_rdata  in  32  instruction ROM read data (combinational)
- pc  out  32  current IF PC
- if_id_instr  out  32  latched instruction (controller A = [31:26], B = [5:0])
- if_id_pc4  out  32  latched PC+4
- if_id_pc8  out  32  latched PC+8, link value for jal/jialc/bnzalr
- fetch_fault  out  1  registered; PC misaligned or out of IM range on the last fetch

Behaviour:
- reset dominates every other input. At the next clk edge:
  - pc = RESET_PC
  - if_id_instr = NOP_WORD
  - if_id_pc4 = RESET_PC
  - if_id_pc8 = RESET_PC+4
  - fetch_fault = 0
- imem_addr = pc[IM_AW+1:2], combinational.
- Fetch word:
  - in range (pc[1:0]==0 and (pc-RESET_PC)>>2 < 2^IM_AW): fetch word = imem_rdata
  - otherwise: fetch word = NOP_WORD and fetch_fault is set at the edge.
- Next PC (pure combinational, npc), with priority jsel first, then branch, then sequential:
  - jsel 001/011: {if_id_pc4[31:28], id_imm26, 2'b00}
  - jsel 010: id_rs_val
  - jsel 100/101: id_rs_val + sign_ext(id_imm16)
  - else if id_br_taken: if_id_pc4 + (sign_ext(id_imm16) << 2)
  - else: pc + 4
  - Other jsel codes (110/111) behave as 000.
- Both id_br_taken and a nonzero jsel asserted: jsel wins. The decode stage guarantees exclusivity, but the bench checks this anyway.
- When stall=0, each edge loads:
  - pc <= npc
  - if_id_instr <= fetch word
  - if_id_pc4 <= pc+4
  - if_id_pc8 <= pc+8
- When stall=1: pc and all if_id_* hold. The redirect stays pending because ID is held, and it is applied on the first unstalled edge.
- Delay slot: the instruction fetched in the redirect cycle (at pc+4 of the branch) always enters IF/ID. Nothing is squashed.
- Latency: IF to IF/ID output is 1 cycle. Redirect takes effect on the PC 1 cycle after the branch or jump is in ID.
- Arithmetic is 32-bit and wraps modulo 2^32. A misaligned target is loaded into pc as-is and raises fetch_fault on the following edge. No trap.
- fetch_fault updates only on unstalled edges.

Decomposition:
- Shared package cpu_defs:
  - JSEL_NONE/JAL/JR/J/JIALC/JI constants, 3 bits
  - RESET_PC_DEF
  - NOP_WORD_DEF
- Sub-module npc: combinational next-PC mux (inputs pc, if_id_pc4, id_jsel, id_br_taken, id_imm16, id_imm26, id_rs_val). The PC register and the IF/ID register stay in fetch_stage.

Test Plan:
- Reset mid-run:
  - Stimulus: ROM preloaded, assert reset for 1 cycle while pc=0x3010.
  - Required: pc=0x3000, if_id_instr=0, if_id_pc4=0x3000, if_id_pc8=0x3004, fetch_fault=0.
- Sequential fetch:
  - Stimulus: 4 free-running cycles.
  - Required: pc goes 0x3000 -> 0x3004 -> 0x3008 -> 0x300C, and if_id_instr equals the ROM word at the previous PC each cycle.
- Taken branch with delay slot:
  - Stimulus: beq at 0x3008 with imm16=0x0003 and id_br_taken=1 while in ID.
  - Required: the word at 0x300C enters IF/ID, and pc becomes 0x300C+12 = 0x3018.
- j and jr:
  - j: imm26=0x0000C10, in ID -> pc=0x00003040.
  - jr: id_rs_val=0x3100 -> pc=0x3100.
  - Both: if_id_pc8 of the jal/jialc instruction equals its PC+8.
- Stall during redirect:
  - Stimulus: jsel=011 with stall=1 for 3 cycles.
  - Required: pc and if_id_* unchanged for all 3 cycles; target loaded on the first edge after stall drops.
- Fault:
  - Stimulus: jr with id_rs_val=0x3002.
  - Required: pc=0x3002, next IF/ID word = NOP_WORD, fetch_fault=1.
  - Stimulus: a jump to 0x4000 with IM_AW=10.
  - Required: out of range, fetch_fault=1.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions: jump-select codes, reset PC and the NOP word.
// Also holds the immediate sign-extension helper used by the fetch and decode logic.
package cpu_defs;

    localparam logic [2:0] JSEL_NONE  = 3'b000;
    localparam logic [2:0] JSEL_JAL   = 3'b001;
    localparam logic [2:0] JSEL_JR    = 3'b010;
    localparam logic [2:0] JSEL_J     = 3'b011;
    localparam logic [2:0] JSEL_JIALC = 3'b100;
    localparam logic [2:0] JSEL_JI    = 3'b101;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-ROM bus between the fetch stage (master) and the ROM (slave).
// The ROM answers combinationally in the same cycle as the address.
interface fetch_stage_if #(
    parameter int AW = 10
);
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage_npc.sv
// Combinational next-PC select: jump select first, then taken branch, then PC+4.
// Unused jump-select codes fall through to branch/sequential handling.
module npc
    import cpu_defs::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] if_id_pc4,
    input  logic [2:0]  id_jsel,
    input  logic        id_br_taken,
    input  logic [15:0] id_imm16,
    input  logic [25:0] id_imm26,
    input  logic [31:0] id_rs_val,
    output logic [31:0] npc
);

    logic [31:0] imm_sx;

    assign imm_sx = sext16(id_imm16);

    always_comb begin
        npc = pc + 32'd4;
        if (id_br_taken) begin
            npc = if_id_pc4 + (imm_sx << 2);
        end
        case (id_jsel)
            JSEL_JAL, JSEL_J:   npc = {if_id_pc4[31:28], id_imm26, 2'b00};
            JSEL_JR:            npc = id_rs_val;
            JSEL_JIALC, JSEL_JI: npc = id_rs_val + imm_sx;
            default:            ;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction-ROM addressing and the IF/ID pipeline register.
// Redirects use one architectural delay slot, so nothing is ever squashed here.
module fetch_stage
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          IM_AW    = 10,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [2:0]           id_jsel,
    input  logic                 id_br_taken,
    input  logic [15:0]          id_imm16,
    input  logic [25:0]          id_imm26,
    input  logic [31:0]          id_rs_val,
    fetch_stage_if.master        imem,
    output logic [31:0]          pc,
    output logic [31:0]          if_id_instr,
    output logic [31:0]          if_id_pc4,
    output logic [31:0]          if_id_pc8,
    output logic                 fetch_fault
);

    logic [31:0] next_pc;
    logic [31:0] pc_off;
    logic        fetch_ok;
    logic [31:0] fetch_word;

    assign imem.imem_addr = pc[IM_AW+1:2];

    // Range is measured from the ROM base so the window wraps cleanly at 2^32.
    assign pc_off     = pc - RESET_PC;
    assign fetch_ok   = (pc[1:0] == 2'b00) && (pc_off[31:IM_AW+2] == '0);
    assign fetch_word = fetch_ok ? imem.imem_rdata : NOP_WORD;

    npc u_npc (
        .pc          (pc),
        .if_id_pc4   (if_id_pc4),
        .id_jsel     (id_jsel),
        .id_br_taken (id_br_taken),
        .id_imm16    (id_imm16),
        .id_imm26    (id_imm26),
        .id_rs_val   (id_rs_val),
        .npc         (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_id_instr <= NOP_WORD;
            if_id_pc4   <= RESET_PC;
            if_id_pc8   <= RESET_PC + 32'd4;
            fetch_fault <= 1'b0;
        end else if (!stall) begin
            pc          <= next_pc;
            if_id_instr <= fetch_word;
            if_id_pc4   <= pc + 32'd4;
            if_id_pc8   <= pc + 32'd8;
            fetch_fault <= !fetch_ok;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized redirects,
// all compared against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  id_jsel = '0;
  logic        id_br_taken = 1'b0;
  logic [15:0] id_imm16 = '0;
  logic [25:0] id_imm26 = '0;
  logic [31:0] id_rs_val = '0;
  logic [31:0] pc, if_id_instr, if_id_pc4, if_id_pc8;
  logic        fetch_fault;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rom [1024];

  // model state
  logic [31:0] m_pc, m_instr, m_pc4, m_pc8;
  logic        m_fault;

  always #5 clk = ~clk;

  fetch_stage_if #(.AW(10)) imem ();
  assign imem.imem_rdata = rom[imem.imem_addr];

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .id_jsel     (id_jsel),
    .id_br_taken (id_br_taken),
    .id_imm16    (id_imm16),
    .id_imm26    (id_imm26),
    .id_rs_val   (id_rs_val),
    .imem        (imem),
    .pc          (pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_pc8   (if_id_pc8),
    .fetch_fault (fetch_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic fetch_valid(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h0000_3000;
    return (a % 4 == 0) && ((off / 4) < 32'd1024);
  endfunction

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_pc"},    pc,          m_pc);
    check({tag, "_instr"}, if_id_instr, m_instr);
    check({tag, "_pc4"},   if_id_pc4,   m_pc4);
    check({tag, "_pc8"},   if_id_pc8,   m_pc8);
    check({tag, "_fault"}, {31'b0, fetch_fault}, {31'b0, m_fault});
    check({tag, "_iaddr"}, {22'b0, imem.imem_addr}, (m_pc / 4) % 1024);
  endtask

  task automatic step(input logic r, input logic s, input logic [2:0] js, input logic br,
                      input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs,
                      input string tag);
    logic [31:0] n_pc, n_instr, n_pc4, n_pc8;
    logic        n_fault;
    reset = r; stall = s; id_jsel = js; id_br_taken = br;
    id_imm16 = i16; id_imm26 = i26; id_rs_val = rs;
    n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_pc8 = m_pc8; n_fault = m_fault;
    if (r) begin
      n_pc = 32'h3000; n_instr = 32'h0; n_pc4 = 32'h3000; n_pc8 = 32'h3004; n_fault = 1'b0;
    end else if (!s) begin
      n_instr = fetch_valid(m_pc) ? rom[(m_pc - 32'h3000) / 4] : 32'h0;
      n_fault = !fetch_valid(m_pc);
      n_pc4   = m_pc + 4;
      n_pc8   = m_pc + 8;
      if (js == 3'd1 || js == 3'd3)      n_pc = (m_pc4 & 32'hF000_0000) + {6'b0, i26} * 4;
      else if (js == 3'd2)               n_pc = rs;
      else if (js == 3'd4 || js == 3'd5) n_pc = rs + sx(i16);
      else if (br)                       n_pc = m_pc4 + sx(i16) * 4;
      else                               n_pc = m_pc + 4;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_pc8 = n_pc8; m_fault = n_fault;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, tag);
  endtask

  initial begin
    logic [31:0] s_pc, s_instr, s_pc4, s_pc8;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom | 32'h1;
    m_pc = 'x; m_instr = 'x; m_pc4 = 'x; m_pc8 = 'x; m_fault = 1'bx;
    #2;

    // reset
    step(1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, "rst");
    step(1'b1, 1'b1, 3'd3, 1'b1, 16'h5, 26'h1, 32'h5, "rst2");
    check("rst_pc", pc, 32'h3000);
    check("rst_pc8", if_id_pc8, 32'h3004);

    // sequential fetch
    idle("seq1"); check("seq1_lit", pc, 32'h3004); check("seq1_w", if_id_instr, rom[0]);
    idle("seq2"); check("seq2_lit", pc, 32'h3008); check("seq2_w", if_id_instr, rom[1]);
    idle("seq3"); check("seq3_lit", pc, 32'h300C); check("seq3_w", if_id_instr, rom[2]);
    idle("seq4"); check("seq4_lit", pc, 32'h3010);

    // reset mid-run
    step(1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, "mrst");
    check("mrst_pc", pc, 32'h3000);
    check("mrst_instr", if_id_instr, 32'h0);
    check("mrst_pc4", if_id_pc4, 32'h3000);
    check("mrst_pc8", if_id_pc8, 32'h3004);
    check("mrst_fault", {31'b0, fetch_fault}, 32'h0);

    // taken branch: beq at 0x3008 sits in ID once pc reaches 0x300C
    idle("br_a"); idle("br_b"); idle("br_c");
    check("br_in_id", if_id_pc4, 32'h300C);
    step(1'b0, 1'b0, 3'd0, 1'b1, 16'h0003, 26'h0, 32'h0, "br");
    check("br_target", pc, 32'h3018);
    check("br_slot", if_id_instr, rom[3]);

    // j, jr, then a jal link check
    step(1'b0, 1'b0, 3'd3, 1'b0, 16'h0, 26'h0000C10, 32'h0, "j");
    check("j_target", pc, 32'h3040);
    step(1'b0, 1'b0, 3'd2, 1'b0, 16'h0, 26'h0, 32'h3100, "jr");
    check("jr_target", pc, 32'h3100);
    check("jal_link", if_id_pc8, 32'h3048);
    step(1'b0, 1'b0, 3'd1, 1'b0, 16'h0, 26'h0000C80, 32'h0, "jal");
    check("jal_target", pc, 32'h3200);
    // jsel wins over a simultaneous taken branch
    step(1'b0, 1'b0, 3'd2, 1'b1, 16'h0010, 26'h0, 32'h3300, "prio");
    check("prio_target", pc, 32'h3300);

    // stall during redirect
    s_pc = pc; s_instr = if_id_instr; s_pc4 = if_id_pc4; s_pc8 = if_id_pc8;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 3'd3, 1'b0, 16'h0, 26'h0000D00, 32'h0, "stall");
      check("stall_pc", pc, s_pc);
      check("stall_instr", if_id_instr, s_instr);
      check("stall_pc4", if_id_pc4, s_pc4);
      check("stall_pc8", if_id_pc8, s_pc8);
    end
    step(1'b0, 1'b0, 3'd3, 1'b0, 16'h0, 26'h0000D00, 32'h0, "unstall");
    check("unstall_pc", pc, 32'h3400);

    // faults: misaligned and out of range
    step(1'b0, 1'b0, 3'd2, 1'b0, 16'h0, 26'h0, 32'h3002, "mis");
    check("mis_pc", pc, 32'h3002);
    idle("mis_f");
    check("mis_fault", {31'b0, fetch_fault}, 32'h1);
    check("mis_nop", if_id_instr, 32'h0);
    step(1'b0, 1'b0, 3'd2, 1'b0, 16'h0, 26'h0, 32'h4000, "oor");
    idle("oor_f");
    check("oor_fault", {31'b0, fetch_fault}, 32'h1);
    check("oor_nop", if_id_instr, 32'h0);
    step(1'b0, 1'b0, 3'd2, 1'b0, 16'h0, 26'h0, 32'h3000, "back");
    idle("back_f");
    check("back_fault", {31'b0, fetch_fault}, 32'h0);

    // randomized redirects, stalls and resets
    for (int n = 0; n < 400; n++) begin
      logic        r, s, br;
      logic [2:0]  js;
      logic [15:0] i16;
      logic [25:0] i26;
      logic [31:0] rs, tgt;
      r   = ($urandom_range(0, 39) == 0);
      s   = ($urandom_range(0, 4) == 0);
      js  = 3'($urandom_range(0, 7));
      br  = ($urandom_range(0, 3) == 0);
      i16 = 16'($urandom_range(0, 63)) - 16'd32;
      tgt = 32'h3000 + 32'($urandom_range(0, 1023)) * 4;
      i26 = 26'(tgt / 4);
      rs  = tgt;
      case ($urandom_range(0, 9))
        0: rs = tgt + 32'($urandom_range(1, 3));
        1: rs = 32'h4000 + 32'($urandom_range(0, 255)) * 4;
        2: rs = 32'($urandom);
        default: ;
      endcase
      step(r, s, js, br, i16, i26, rs, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
